// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Single-outstanding instruction fetch with IF/ID register and
//             PC stall feedback.
//  Revision : 1.0
// ============================================================================
module fetch_unit #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc,
    output logic            stall_fetch_stg,
    input  logic            stall_decode_stg,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    output logic [XLEN-1:0] pc_plus4_d,
    output logic            valid_d,
    output logic            misalign_d
);

    localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_tag;
    logic [XLEN-1:0] r_hold_data;
    logic            w_accept;
    logic            w_capture;
    logic            w_load_rsp;
    logic            w_load_hold;

    assign imem_req_addr = {pc[XLEN-1:2], 2'b00};
    assign w_accept      = (r_state == IDLE) && imem_req_ready;

    always_comb begin
        w_state_nxt     = r_state;
        imem_req_valid  = 1'b0;
        stall_fetch_stg = 1'b1;
        w_capture       = 1'b0;
        w_load_rsp      = 1'b0;
        w_load_hold     = 1'b0;
        if (rst) begin
            case (r_state)
                IDLE: begin
                    imem_req_valid = 1'b1;
                    if (imem_req_ready) begin
                        w_state_nxt = flush ? DROP : WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (flush) begin
                            w_state_nxt = IDLE;
                        end else if (!stall_decode_stg) begin
                            w_load_rsp      = 1'b1;
                            stall_fetch_stg = 1'b0;
                            w_state_nxt     = IDLE;
                        end else begin
                            w_capture   = 1'b1;
                            w_state_nxt = HOLD;
                        end
                    end else if (flush) begin
                        w_state_nxt = DROP;
                    end
                end
                HOLD: begin
                    if (flush) begin
                        w_state_nxt = IDLE;
                    end else if (!stall_decode_stg) begin
                        w_load_hold     = 1'b1;
                        stall_fetch_stg = 1'b0;
                        w_state_nxt     = IDLE;
                    end
                end
                DROP: begin
                    // The stale response retires DROP even if another flush
                    // arrives with it; nothing else is left outstanding.
                    if (imem_rsp_valid) begin
                        w_state_nxt = IDLE;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
            if (flush) begin
                stall_fetch_stg = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= IDLE;
            r_tag       <= '0;
            r_hold_data <= '0;
            valid_d     <= 1'b0;
            instr_d     <= NOP_INSTR;
            pc_d        <= '0;
            pc_plus4_d  <= '0;
            misalign_d  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_tag <= pc;
            end
            if (w_capture) begin
                r_hold_data <= imem_rsp_data;
            end
            if (flush) begin
                valid_d <= 1'b0;
                instr_d <= NOP_INSTR;
            end else if (w_load_rsp || w_load_hold) begin
                instr_d    <= w_load_rsp ? imem_rsp_data : r_hold_data;
                pc_d       <= r_tag;
                pc_plus4_d <= r_tag + c_PC_STEP;
                misalign_d <= (r_tag[1:0] != 2'b00);
                valid_d    <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Bench for fetch_unit with PC and instruction-memory models.
//  Revision : 1.0
// ============================================================================
module tb_fetch_unit;

    localparam logic [31:0] c_NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] pc = '0;
    logic        stall_fetch_stg;
    logic        stall_decode_stg = 1'b0;
    logic        flush = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b1;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4_d;
    logic        valid_d;
    logic        misalign_d;

    int checks = 0;
    int errors = 0;

    // memory / program-counter model state
    bit          mem_pend = 1'b0;
    logic [31:0] mem_addr = '0;
    int          mem_cnt = 0;
    int          lat = 1;
    bit          lat_rand = 1'b0;
    int          ready_pct = 100;
    logic [31:0] redirect_pc = '0;
    bit          last_adv = 1'b0;
    bit          last_flush = 1'b0;

    wire [97:0] ifid = {valid_d, misalign_d, pc_d, pc_plus4_d, instr_d};

    fetch_unit #(.XLEN(32), .NOP_INSTR(32'h00000013)) dut (
        .clk              (clk),
        .rst              (rst),
        .pc               (pc),
        .stall_fetch_stg  (stall_fetch_stg),
        .stall_decode_stg (stall_decode_stg),
        .flush            (flush),
        .imem_req_valid   (imem_req_valid),
        .imem_req_ready   (imem_req_ready),
        .imem_req_addr    (imem_req_addr),
        .imem_rsp_valid   (imem_rsp_valid),
        .imem_rsp_data    (imem_rsp_data),
        .instr_d          (instr_d),
        .pc_d             (pc_d),
        .pc_plus4_d       (pc_plus4_d),
        .valid_d          (valid_d),
        .misalign_d       (misalign_d)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h13572468;
    endfunction

    function automatic logic [97:0] ifid_exp(input logic [31:0] p);
        logic [31:0] al;
        al = {p[31:2], 2'b00};
        return {1'b1, (p[1:0] != 2'b00), p, p + 32'd4, mem_word(al)};
    endfunction

    // One clock: sample at negedge, then update PC and memory models after the edge.
    task automatic cycle();
        logic        fire, rspv, adv;
        logic [31:0] raddr;
        @(negedge clk);
        fire  = imem_req_valid && imem_req_ready;
        raddr = imem_req_addr;
        rspv  = imem_rsp_valid;
        adv   = !stall_fetch_stg;
        @(posedge clk);
        #1;
        last_adv   = adv;
        last_flush = flush;
        if (!rst) begin
            mem_pend       = 1'b0;
            imem_rsp_valid = 1'b0;
        end else begin
            if (adv) pc = flush ? redirect_pc : pc + 32'd4;
            if (rspv) imem_rsp_valid = 1'b0;
            if (fire) begin
                mem_pend = 1'b1;
                mem_addr = raddr;
                mem_cnt  = lat_rand ? int'($urandom_range(1, 4)) : lat;
            end
            if (mem_pend) begin
                mem_cnt--;
                if (mem_cnt <= 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = mem_word(mem_addr);
                    mem_pend       = 1'b0;
                end
            end
        end
        imem_req_ready = (int'($urandom_range(0, 99)) < ready_pct);
    endtask

    task automatic wait_commit(input string name);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!last_adv && n < 20);
        #1;
        checks++;
        if (!last_adv) begin
            errors++;
            $display("FAIL %s_timeout: no commit within %0d cycles", name, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) cycle();
        #1;
        checks++;
        if (ifid !== {1'b0, 1'b0, 32'h0, 32'h0, c_NOP}) begin
            errors++;
            $display("FAIL reset_ifid: got %h expected %h", ifid, {1'b0, 1'b0, 32'h0, 32'h0, c_NOP});
        end
        checks++;
        if ({imem_req_valid, stall_fetch_stg} !== 2'b01) begin
            errors++;
            $display("FAIL reset_ctrl: got req_valid/stall=%b expected 01", {imem_req_valid, stall_fetch_stg});
        end
    endtask

    task automatic test_basic();
        rst = 1'b1;
        pc  = 32'h0;
        #1;
        checks++;
        if ({imem_req_valid, stall_fetch_stg, imem_req_addr} !== {2'b11, 32'h0}) begin
            errors++;
            $display("FAIL basic_req0: got %h expected %h", {imem_req_valid, stall_fetch_stg, imem_req_addr}, {2'b11, 32'h0});
        end
        for (int k = 0; k < 2; k++) begin
            cycle();
            #1;
            checks++;
            if (stall_fetch_stg !== 1'b0) begin
                errors++;
                $display("FAIL basic_stall_pulse%0d: got %b expected 0", k, stall_fetch_stg);
            end
            cycle();
            #1;
            checks++;
            if (ifid !== ifid_exp(32'(4 * k))) begin
                errors++;
                $display("FAIL basic_ifid%0d: got %h expected %h", k, ifid, ifid_exp(32'(4 * k)));
            end
            checks++;
            if ({imem_req_valid, stall_fetch_stg, imem_req_addr} !== {2'b11, 32'(4 * k + 4)}) begin
                errors++;
                $display("FAIL basic_req%0d: got %h expected %h", k + 1, {imem_req_valid, stall_fetch_stg, imem_req_addr}, {2'b11, 32'(4 * k + 4)});
            end
        end
    endtask

    task automatic test_ready_low();
        pc             = 32'h10;
        ready_pct      = 0;
        imem_req_ready = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({imem_req_valid, stall_fetch_stg, imem_req_addr, pc_d} !== {2'b11, 32'h10, 32'h4}) begin
                errors++;
                $display("FAIL ready_low%0d: got %h expected %h", k, {imem_req_valid, stall_fetch_stg, imem_req_addr, pc_d}, {2'b11, 32'h10, 32'h4});
            end
            cycle();
            #1;
        end
        ready_pct      = 100;
        imem_req_ready = 1'b1;
        wait_commit("ready_low");
        checks++;
        if (ifid !== ifid_exp(32'h10)) begin
            errors++;
            $display("FAIL ready_low_ifid: got %h expected %h", ifid, ifid_exp(32'h10));
        end
    endtask

    task automatic test_hold();
        pc = 32'h20;
        #1;
        cycle();
        stall_decode_stg = 1'b1;
        #1;
        checks++;
        if (stall_fetch_stg !== 1'b1) begin
            errors++;
            $display("FAIL hold_rsp_stall: got %b expected 1", stall_fetch_stg);
        end
        for (int k = 0; k < 2; k++) begin
            cycle();
            #1;
            checks++;
            if ({stall_fetch_stg, ifid} !== {1'b1, ifid_exp(32'h10)}) begin
                errors++;
                $display("FAIL hold_keep%0d: got %h expected %h", k, {stall_fetch_stg, ifid}, {1'b1, ifid_exp(32'h10)});
            end
        end
        stall_decode_stg = 1'b0;
        #1;
        checks++;
        if (stall_fetch_stg !== 1'b0) begin
            errors++;
            $display("FAIL hold_release_stall: got %b expected 0", stall_fetch_stg);
        end
        cycle();
        #1;
        checks++;
        if ({stall_fetch_stg, ifid} !== {1'b1, ifid_exp(32'h20)}) begin
            errors++;
            $display("FAIL hold_release_ifid: got %h expected %h", {stall_fetch_stg, ifid}, {1'b1, ifid_exp(32'h20)});
        end
    endtask

    task automatic test_flush_wait();
        int n;
        pc  = 32'h40;
        lat = 3;
        #1;
        cycle();
        flush       = 1'b1;
        redirect_pc = 32'h100;
        #1;
        checks++;
        if ({imem_rsp_valid, stall_fetch_stg} !== 2'b00) begin
            errors++;
            $display("FAIL flush_wait_stall: got rsp/stall=%b expected 00", {imem_rsp_valid, stall_fetch_stg});
        end
        cycle();
        flush = 1'b0;
        #1;
        checks++;
        if ({valid_d, instr_d, imem_req_valid} !== {1'b0, c_NOP, 1'b0}) begin
            errors++;
            $display("FAIL flush_wait_clear: got %h expected %h", {valid_d, instr_d, imem_req_valid}, {1'b0, c_NOP, 1'b0});
        end
        n = 0;
        while (!imem_req_valid && n < 10) begin
            cycle();
            #1;
            n++;
        end
        lat = 1;
        checks++;
        if ({imem_req_valid, imem_req_addr, valid_d} !== {1'b1, 32'h100, 1'b0}) begin
            errors++;
            $display("FAIL flush_wait_redirect: got %h expected %h", {imem_req_valid, imem_req_addr, valid_d}, {1'b1, 32'h100, 1'b0});
        end
        wait_commit("flush_wait");
        checks++;
        if (ifid !== ifid_exp(32'h100)) begin
            errors++;
            $display("FAIL flush_wait_ifid: got %h expected %h", ifid, ifid_exp(32'h100));
        end
    endtask

    task automatic test_flush_hold();
        stall_decode_stg = 1'b1;
        #1;
        cycle();
        cycle();
        flush       = 1'b1;
        redirect_pc = 32'h300;
        #1;
        checks++;
        if (stall_fetch_stg !== 1'b0) begin
            errors++;
            $display("FAIL flush_hold_stall: got %b expected 0", stall_fetch_stg);
        end
        cycle();
        flush = 1'b0;
        #1;
        checks++;
        if ({valid_d, instr_d, imem_req_valid, imem_req_addr} !== {1'b0, c_NOP, 1'b1, 32'h300}) begin
            errors++;
            $display("FAIL flush_hold_clear: got %h expected %h", {valid_d, instr_d, imem_req_valid, imem_req_addr}, {1'b0, c_NOP, 1'b1, 32'h300});
        end
        stall_decode_stg = 1'b0;
        wait_commit("flush_hold");
        checks++;
        if (ifid !== ifid_exp(32'h300)) begin
            errors++;
            $display("FAIL flush_hold_ifid: got %h expected %h", ifid, ifid_exp(32'h300));
        end
    endtask

    task automatic test_wrap_misalign();
        pc = 32'hFFFFFFFC;
        wait_commit("wrap");
        checks++;
        if ({pc_plus4_d, ifid} !== {32'h0, ifid_exp(32'hFFFFFFFC)}) begin
            errors++;
            $display("FAIL wrap_ifid: got %h expected %h", {pc_plus4_d, ifid}, {32'h0, ifid_exp(32'hFFFFFFFC)});
        end
        pc = 32'h6;
        #1;
        checks++;
        if (imem_req_addr !== 32'h4) begin
            errors++;
            $display("FAIL misalign_addr: got %h expected 00000004", imem_req_addr);
        end
        wait_commit("misalign");
        checks++;
        if ({misalign_d, pc_d, pc_plus4_d, instr_d} !== {1'b1, 32'h6, 32'hA, mem_word(32'h4)}) begin
            errors++;
            $display("FAIL misalign_ifid: got %h expected %h", {misalign_d, pc_d, pc_plus4_d, instr_d}, {1'b1, 32'h6, 32'hA, mem_word(32'h4)});
        end
    endtask

    task automatic test_reset_mid();
        pc  = 32'h80;
        lat = 3;
        #1;
        cycle();
        rst = 1'b0;
        #1;
        cycle();
        #1;
        checks++;
        if ({ifid, imem_req_valid, stall_fetch_stg} !== {1'b0, 1'b0, 32'h0, 32'h0, c_NOP, 2'b01}) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h", {ifid, imem_req_valid, stall_fetch_stg}, {1'b0, 1'b0, 32'h0, 32'h0, c_NOP, 2'b01});
        end
        rst = 1'b1;
        pc  = 32'h0;
        lat = 1;
        wait_commit("reset_mid");
        checks++;
        if (ifid !== ifid_exp(32'h0)) begin
            errors++;
            $display("FAIL reset_mid_refetch: got %h expected %h", ifid, ifid_exp(32'h0));
        end
    endtask

    task automatic test_random();
        logic [97:0] snap;
        logic [31:0] pc_before;
        int          commits;
        commits   = 0;
        pc        = $urandom;
        lat_rand  = 1'b1;
        ready_pct = 70;
        for (int i = 0; i < 1500; i++) begin
            stall_decode_stg = ($urandom_range(0, 99) < 30);
            flush            = !imem_rsp_valid && ($urandom_range(0, 99) < 5);
            redirect_pc      = $urandom;
            #1;
            if (imem_req_valid) begin
                checks++;
                if (imem_req_addr !== {pc[31:2], 2'b00} || mem_pend || imem_rsp_valid) begin
                    errors++;
                    $display("FAIL rand_req@%0d: addr %h expected %h, outstanding=%b expected 0", i, imem_req_addr, {pc[31:2], 2'b00}, mem_pend | imem_rsp_valid);
                end
            end
            if (flush || stall_decode_stg) begin
                checks++;
                if (stall_fetch_stg !== !flush) begin
                    errors++;
                    $display("FAIL rand_stall@%0d: got %b expected %b", i, stall_fetch_stg, !flush);
                end
            end
            snap      = ifid;
            pc_before = pc;
            cycle();
            checks++;
            if (last_flush) begin
                if ({valid_d, instr_d} !== {1'b0, c_NOP}) begin
                    errors++;
                    $display("FAIL rand_flush@%0d: got %h expected %h", i, {valid_d, instr_d}, {1'b0, c_NOP});
                end
            end else if (last_adv) begin
                commits++;
                if (ifid !== ifid_exp(pc_before)) begin
                    errors++;
                    $display("FAIL rand_commit@%0d: got %h expected %h", i, ifid, ifid_exp(pc_before));
                end
            end else if (ifid !== snap) begin
                errors++;
                $display("FAIL rand_hold@%0d: got %h expected %h", i, ifid, snap);
            end
        end
        flush            = 1'b0;
        stall_decode_stg = 1'b0;
        checks++;
        if (commits < 50) begin
            errors++;
            $display("FAIL rand_progress: got %0d commits expected at least 50", commits);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_ready_low();
        test_hold();
        test_flush_wait();
        test_flush_hold();
        test_wrap_misalign();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire
